// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory read bus between fetch and the instruction memory
interface fetch_stage_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 17
);
  logic [ADDR_W-1:0]  im_addr;
  logic               im_rd_en;
  logic [INSTR_W-1:0] im_rdata;

  // fetch side issues reads and consumes read data
  modport master (
    output im_addr,
    output im_rd_en,
    input  im_rdata
  );

  // memory side answers one cycle after a read enable
  modport slave (
    input  im_addr,
    input  im_rd_en,
    output im_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with skid register and redirect
module fetch_stage #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 17,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_IM_ID,
  input  logic               flow_change_ID_EX,
  input  logic [ADDR_W-1:0]  dst_ID_EX,
  fetch_stage_if.master      im,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_vld,
  output logic [ADDR_W-1:0]  nxt_pc_IM_ID,
  output logic [ADDR_W-1:0]  nxt_pc_ID_EX
);

  logic [ADDR_W-1:0]  pc;
  logic               rsp_vld;
  logic [ADDR_W-1:0]  rsp_pc;
  logic               skid_vld;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc;

  logic               src_vld;
  logic [ADDR_W-1:0]  src_pc;
  logic [INSTR_W-1:0] src_instr;

  // Read issue: redirect beats stall; reset suppresses all reads
  always_comb begin
    im.im_addr  = pc;
    im.im_rd_en = 1'b0;
    if (!rst) begin
      if (flow_change_ID_EX) begin
        im.im_addr  = dst_ID_EX;
        im.im_rd_en = 1'b1;
      end else if (!stall_IM_ID) begin
        im.im_rd_en = 1'b1;
      end
    end
  end

  // Instruction presented to decode: a held skid entry beats the live memory response
  always_comb begin
    src_vld   = 1'b0;
    src_pc    = rsp_pc;
    src_instr = '0;
    if (!rst) begin
      if (skid_vld) begin
        src_vld   = 1'b1;
        src_pc    = skid_pc;
        src_instr = skid_instr;
      end else if (rsp_vld) begin
        src_vld   = 1'b1;
        src_pc    = rsp_pc;
        src_instr = im.im_rdata;
      end
    end
    instr     = src_instr;
    instr_vld = src_vld;
  end

  // PC, response tracking, skid capture and next-PC pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      rsp_vld      <= 1'b0;
      skid_vld     <= 1'b0;
      nxt_pc_IM_ID <= '0;
      nxt_pc_ID_EX <= '0;
    end else begin
      nxt_pc_ID_EX <= nxt_pc_IM_ID;
      if (!stall_IM_ID) begin
        nxt_pc_IM_ID <= src_vld ? src_pc + ADDR_W'(1) : '0;
      end
      if (flow_change_ID_EX) begin
        // wrong-path response and any held skid entry are dropped here
        pc       <= dst_ID_EX + ADDR_W'(1);
        rsp_vld  <= 1'b1;
        rsp_pc   <= dst_ID_EX;
        skid_vld <= 1'b0;
      end else if (stall_IM_ID) begin
        rsp_vld <= 1'b0;
        // only the response already in flight when the stall began needs saving
        if (rsp_vld && !skid_vld) begin
          skid_instr <= im.im_rdata;
          skid_pc    <= rsp_pc;
          skid_vld   <= 1'b1;
        end
      end else begin
        pc       <= pc + ADDR_W'(1);
        rsp_vld  <= 1'b1;
        rsp_pc   <= pc;
        skid_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flow;
  logic [15:0] dst;
  logic [16:0] instr;
  logic        instr_vld;
  logic [15:0] nxt_id, nxt_ex;

  fetch_stage_if #(.ADDR_W(16), .INSTR_W(17)) im ();

  fetch_stage #(.ADDR_W(16), .INSTR_W(17), .RESET_PC(16'h0000)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_IM_ID       (stall),
    .flow_change_ID_EX (flow),
    .dst_ID_EX         (dst),
    .im                (im),
    .instr             (instr),
    .instr_vld         (instr_vld),
    .nxt_pc_IM_ID      (nxt_id),
    .nxt_pc_ID_EX      (nxt_ex)
  );

  // memory word at address k is {1, k}, so data is never the bubble encoding
  always @(posedge clk) if (im.im_rd_en) im.im_rdata <= {1'b1, im.im_addr};

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // reference model: the in-order program stream decode should see
  bit          m_init = 0;
  bit          m_issued;
  logic [15:0] m_exp_pc, m_fetch, m_nxt, m_nxt_ex;

  task automatic model_check();
    if (!m_init) return;
    if (rst) begin
      chk("rst_rd_en", im.im_rd_en, 0);
      chk("rst_vld", instr_vld, 0);
      chk("rst_instr", instr, 0);
    end else begin
      chk("m_rd_en", im.im_rd_en, (flow || !stall));
      if (flow) chk("m_addr_redirect", im.im_addr, dst);
      else      chk("m_addr", im.im_addr, m_fetch);
      chk("m_vld", instr_vld, m_issued);
      chk("m_instr", instr, m_issued ? {15'b0, 1'b1, m_exp_pc} : 32'd0);
    end
    chk("m_nxt_IM_ID", nxt_id, m_nxt);
    chk("m_nxt_ID_EX", nxt_ex, m_nxt_ex);
  endtask

  task automatic model_update();
    if (rst) begin
      m_init = 1; m_issued = 0;
      m_fetch = 16'h0000; m_exp_pc = 16'h0000;
      m_nxt = 0; m_nxt_ex = 0;
    end else begin
      m_nxt_ex = m_nxt;
      if (!stall) begin
        m_nxt = m_issued ? 16'(m_exp_pc + 16'd1) : 16'd0;
        if (m_issued) m_exp_pc = 16'(m_exp_pc + 16'd1);
      end
      if (flow) begin
        m_exp_pc = dst; m_fetch = 16'(dst + 16'd1); m_issued = 1;
      end else if (!stall) begin
        m_fetch = 16'(m_fetch + 16'd1); m_issued = 1;
      end
    end
  endtask

  task automatic set_in(input logic r, input logic s, input logic f, input logic [15:0] d);
    rst = r; stall = s; flow = f; dst = d;
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic fin();
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic        r, s, f;
    logic [15:0] d;
    logic        e_rd;
    logic [15:0] e_addr;
    logic        e_vld;
    logic [16:0] e_instr;
    logic        c_nxt;
    logic [15:0] e_nxt;
  } vec_t;

  vec_t tv[20];

  initial begin
    tv[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 17'h00000, 1'b0, 16'h0000};
    tv[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 17'h00000, 1'b1, 16'h0000};
    tv[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 17'h00000, 1'b1, 16'h0000};
    tv[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b1, 17'h10000, 1'b1, 16'h0000};
    tv[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 17'h10001, 1'b1, 16'h0001};
    tv[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b1, 17'h10002, 1'b1, 16'h0002};
    tv[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 17'h10003, 1'b1, 16'h0003};
    tv[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b1, 17'h10004, 1'b1, 16'h0004};
    tv[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 17'h10005, 1'b1, 16'h0005};
    tv[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 17'h10005, 1'b1, 16'h0005};
    tv[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 17'h10005, 1'b1, 16'h0005};
    tv[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 17'h10005, 1'b1, 16'h0005};
    tv[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0007, 1'b1, 17'h10006, 1'b1, 16'h0006};
    tv[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b1, 17'h10007, 1'b1, 16'h0007};
    tv[14] = '{1'b0, 1'b0, 1'b1, 16'h0040, 1'b1, 16'h0040, 1'b1, 17'h10008, 1'b1, 16'h0008};
    tv[15] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0041, 1'b1, 17'h10040, 1'b1, 16'h0009};
    tv[16] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0042, 1'b1, 17'h10041, 1'b1, 16'h0041};
    tv[17] = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 17'h10042, 1'b1, 16'h0042};
    tv[18] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 17'h1FFFF, 1'b1, 16'h0043};
    tv[19] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b1, 17'h10000, 1'b1, 16'h0000};

    // directed table: reset, sequential fetch, 3-cycle stall, redirect, wrap
    for (int i = 0; i < 20; i++) begin
      set_in(tv[i].r, tv[i].s, tv[i].f, tv[i].d);
      at_neg();
      chk($sformatf("tv%0d_rd_en", i), im.im_rd_en, tv[i].e_rd);
      if (!tv[i].r) chk($sformatf("tv%0d_addr", i), im.im_addr, tv[i].e_addr);
      chk($sformatf("tv%0d_vld", i), instr_vld, tv[i].e_vld);
      chk($sformatf("tv%0d_instr", i), instr, tv[i].e_instr);
      if (tv[i].c_nxt) chk($sformatf("tv%0d_nxt", i), nxt_id, tv[i].e_nxt);
      fin();
    end

    // redirect while stalled with a held skid entry
    set_in(0, 1, 0, 0); at_neg(); chk("p4_rsp", instr, 17'h10001); fin();
    set_in(0, 1, 0, 0); at_neg(); chk("p4_skid", instr, 17'h10001);
    chk("p4_stall_rd", im.im_rd_en, 0); fin();
    set_in(0, 1, 1, 16'h0100); at_neg();
    chk("p4_redir_rd", im.im_rd_en, 1); chk("p4_redir_addr", im.im_addr, 16'h0100); fin();
    set_in(0, 1, 0, 0); at_neg();
    chk("p4_target", instr, 17'h10100); chk("p4_target_vld", instr_vld, 1); fin();
    set_in(0, 0, 0, 0); at_neg();
    chk("p4_release_instr", instr, 17'h10100); chk("p4_release_addr", im.im_addr, 16'h0101); fin();

    // reset in the middle of a stall with the skid full
    set_in(0, 1, 0, 0); at_neg(); chk("p6_rsp", instr, 17'h10101); fin();
    set_in(0, 1, 0, 0); at_neg(); chk("p6_skid", instr, 17'h10101); fin();
    set_in(1, 1, 0, 0); at_neg();
    chk("p6_rst_instr", instr, 0); chk("p6_rst_vld", instr_vld, 0); chk("p6_rst_rd", im.im_rd_en, 0); fin();
    set_in(1, 0, 0, 0); at_neg(); chk("p6_rst2_instr", instr, 0); fin();
    set_in(0, 0, 0, 0); at_neg();
    chk("p6_first_addr", im.im_addr, 16'h0000); chk("p6_first_rd", im.im_rd_en, 1);
    chk("p6_first_vld", instr_vld, 0); fin();
    set_in(0, 0, 0, 0); at_neg();
    chk("p6_first_instr", instr, 17'h10000); chk("p6_first_instr_vld", instr_vld, 1); fin();

    // randomized traffic checked against the stream model
    for (int n = 0; n < 3000; n++) begin
      logic        r, s, f;
      logic [15:0] d;
      r = ($urandom_range(63) == 0);
      s = ($urandom_range(2) == 0);
      f = ($urandom_range(7) == 0);
      case ($urandom_range(3))
        0:       d = 16'hFFFF;
        1:       d = 16'(16'hFFFE + $urandom_range(3));
        default: d = 16'($urandom);
      endcase
      set_in(r, s, f, d);
      at_neg();
      fin();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
